// File: rtl/uart_rx_deserializer.sv
// 16x-oversampled UART receiver: 8N1 by default, 8E1 when UART_RX_PARITY_EN is defined.
// Emits one-cycle rx_status on a good byte and frame_err on a bad stop/parity bit.
module uart_rx_deserializer #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_status,
  output logic       frame_err
);

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } state_t;

  state_t        state;
  logic [1:0]    sync_q;
  logic          rxs;
  logic [CW-1:0] tick_cnt;
  logic          tick;
  logic [3:0]    os_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          stop_ok;

  assign rxs  = sync_q[1];
  assign tick = (tick_cnt == CW'(DIV - 1));

`ifdef UART_RX_PARITY_EN
  logic par_err;
  assign stop_ok = rxs && !par_err;
`else
  assign stop_ok = rxs;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], uart_rx};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      os_cnt    <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_status <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err   <= 1'b0;
`endif
    end else begin
      rx_status <= 1'b0;
      frame_err <= 1'b0;
      if (tick) begin
        case (state)
          IDLE: begin
            if (!rxs) begin
              state  <= START;
              os_cnt <= '0;
            end
          end
          START: begin
            // mid start bit: a high line here was only a glitch
            if (os_cnt == 4'd7) begin
              os_cnt <= '0;
              if (!rxs) begin
                state   <= DATA;
                bit_cnt <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
          DATA: begin
            if (os_cnt == 4'd15) begin
              shift   <= {rxs, shift[7:1]};
              bit_cnt <= bit_cnt + 1'b1;
              os_cnt  <= '0;
              if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (os_cnt == 4'd15) begin
              par_err <= rxs ^ (^shift);
              os_cnt  <= '0;
              state   <= STOP;
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
`endif
          STOP: begin
            if (os_cnt == 4'd15) begin
              os_cnt <= '0;
              if (stop_ok) begin
                rx_data   <= shift;
                rx_status <= 1'b1;
                state     <= IDLE;
              end else begin
                frame_err <= 1'b1;
                state     <= rxs ? IDLE : WAIT_HIGH;
              end
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
          WAIT_HIGH: begin
            if (rxs) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
